cci_mpf_svc_vtp_req_funnel: RTL and testbench
=============================================

Name: cci_mpf_svc_vtp_req_funnel

Overview:
- Sits directly upstream of the VTP service/page-translation wrapper.
- Merges translation lookup requests from N_PORTS independent clients into the single lookup channel the VTP service consumes.
- Routes each returned translation back to the originating client using a port-index tag.
- Enforces a per-port credit limit on outstanding lookups.

Parameters:
N_PORTS, 4, number of client ports (1..16)
VPAGE_WIDTH, 36, virtual page number width
PPAGE_WIDTH, 32, physical page number width
MAX_OUTSTANDING, 8, maximum unanswered lookups per port (1..255)
TAG_WIDTH, derived: max(1, clog2(N_PORTS)), port-index tag width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous reset, active-low (0 = in reset)
cl_req_valid  in  N_PORTS  per-port lookup request valid
cl_req_rdy  out  N_PORTS  per-port request accept
cl_req_vpage  in  N_PORTS*VPAGE_WIDTH  per-port virtual page; port i occupies bits [i*VPAGE_WIDTH +: VPAGE_WIDTH]
lk_valid  out  1  lookup request to VTP service, registered
lk_rdy  in  1  VTP service accepts lookup
lk_vpage  out  VPAGE_WIDTH  virtual page to translate
lk_tag  out  TAG_WIDTH  originating port index
rsp_valid  in  1  translation response from service, no backpressure
rsp_tag  in  TAG_WIDTH  port index copied from lk_tag
rsp_ppage  in  PPAGE_WIDTH  translated physical page
rsp_error  in  1  translation fault
cl_rsp_valid  out  N_PORTS  one-hot response strobe, registered
cl_rsp_ppage  out  PPAGE_WIDTH  broadcast response page, registered
cl_rsp_error  out  1  broadcast fault flag, registered
idle  out  1  no buffered request and all outstanding counters zero
err_orphan_rsp  out  1  sticky: response arrived for a port with zero outstanding, or a tag >= N_PORTS

Behaviour:
- Reset values (asserted asynchronously): lk_valid=0, lk_vpage=0, lk_tag=0, cl_rsp_valid=0, cl_rsp_ppage=0, cl_rsp_error=0, err_orphan_rsp=0, all outstanding counters=0, round-robin pointer=0, idle=1.
- Output stage is a single register. It can load in a cycle when (!lk_valid || lk_rdy).
- Eligibility: port i is eligible when cl_req_valid[i] && outstanding[i] < MAX_OUTSTANDING.
- Arbitration: round-robin among eligible ports, with priority starting at the pointer.
  - cl_req_rdy[i]=1 only for the single winner, and only when the output stage can load.
  - cl_req_rdy is combinational from valid, counters, pointer and lk_rdy.
- On accept of port i:
  - lk_valid=1, lk_vpage=vpage[i], lk_tag=i on the next edge.
  - outstanding[i] increments.
  - Pointer moves to (i+1) mod N_PORTS.
- Pointer is unchanged in cycles with no accept.
- A held lk_valid keeps lk_vpage/lk_tag stable until lk_rdy. lk_valid drops on the edge after lk_rdy unless a new request loads in the same cycle.
- Throughput: one lookup per cycle when lk_rdy stays high.
- Request-to-lk_valid latency: 1 cycle.
- Response path:
  - A valid response with rsp_tag=t < N_PORTS and outstanding[t] > 0 sets cl_rsp_valid = one-hot(t) for exactly one cycle, 1 cycle after rsp_valid.
  - cl_rsp_ppage and cl_rsp_error are captured on the same edge. They hold their last value when no response arrives.
  - outstanding[t] decrements.
- Simultaneous accept and response on the same port: counter is unchanged.
- Counter saturation: at MAX_OUTSTANDING the port is ineligible and cl_req_rdy[i]=0. It becomes eligible in the cycle after a response decrements its counter.
- Orphan handling: a response with t >= N_PORTS or outstanding[t]==0 is dropped. No cl_rsp_valid is asserted, no counter changes, and err_orphan_rsp is set until reset.
- Ordering: per-port responses are in the order the service returns them. The block does no reordering.
- Reset mid-operation clears all state, including the buffered request and counters. The service must be reset concurrently; otherwise responses still in flight are flagged as orphans.
- idle = !lk_valid && all outstanding==0, registered-state only (no combinational input paths).

Test Plan:
- Single request: port 2 sends vpage 0x123456789 with lk_rdy=1 -> lk_valid the next cycle with lk_tag=2. Return rsp_tag=2, ppage 0xABCDE -> cl_rsp_valid=4'b0100 and cl_rsp_ppage=0xABCDE one cycle later; idle returns to 1.
- Fairness: all 4 ports hold valid continuously with lk_rdy=1 -> lk_tag sequence 0,1,2,3,0,1,... with no gaps.
- Backpressure: lk_rdy=0 for 5 cycles with a request buffered -> lk_vpage/lk_tag stable, all cl_req_rdy=0. lk_rdy=1 -> next request issues the following cycle.
- Credit limit (MAX_OUTSTANDING=8): port 1 issues 8 lookups with no responses -> cl_req_rdy[1]=0 while port 0 is still granted. One response for tag 1 -> port 1 is accepted again the next cycle.
- Simultaneous accept and response on port 3 with outstanding=5 -> counter stays 5 and cl_rsp_valid[3] pulses.
- Orphan: rsp_valid with rsp_tag=0 and zero outstanding -> no cl_rsp_valid, err_orphan_rsp=1 and held. Asserting reset low mid-traffic -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/cci_mpf_svc_vtp_req_funnel.sv
// Funnels VTP translation lookups from N_PORTS clients into one service channel,
// with per-port credit limits and tag-based routing of returned translations.
module cci_mpf_svc_vtp_req_funnel #(
  parameter int unsigned N_PORTS         = 4,
  parameter int unsigned VPAGE_WIDTH     = 36,
  parameter int unsigned PPAGE_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TAG_WIDTH       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_PORTS-1:0]             cl_req_valid,
  output logic [N_PORTS-1:0]             cl_req_rdy,
  input  logic [N_PORTS*VPAGE_WIDTH-1:0] cl_req_vpage,
  output logic                           lk_valid,
  input  logic                           lk_rdy,
  output logic [VPAGE_WIDTH-1:0]         lk_vpage,
  output logic [TAG_WIDTH-1:0]           lk_tag,
  input  logic                           rsp_valid,
  input  logic [TAG_WIDTH-1:0]           rsp_tag,
  input  logic [PPAGE_WIDTH-1:0]         rsp_ppage,
  input  logic                           rsp_error,
  output logic [N_PORTS-1:0]             cl_rsp_valid,
  output logic [PPAGE_WIDTH-1:0]         cl_rsp_ppage,
  output logic                           cl_rsp_error,
  output logic                           idle,
  output logic                           err_orphan_rsp
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                   lk_valid_q, lk_valid_d;
  logic [VPAGE_WIDTH-1:0] lk_vpage_q, lk_vpage_d;
  logic [TAG_WIDTH-1:0]   lk_tag_q, lk_tag_d;
  logic [TAG_WIDTH-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q [N_PORTS];
  logic [CNT_W-1:0]       cnt_d [N_PORTS];
  logic [N_PORTS-1:0]     rsp_valid_q, rsp_valid_d;
  logic [PPAGE_WIDTH-1:0] rsp_ppage_q, rsp_ppage_d;
  logic                   rsp_error_q, rsp_error_d;
  logic                   orphan_q, orphan_d;

  logic                   can_load;
  logic                   found;
  logic [TAG_WIDTH-1:0]   grant_idx;
  logic [N_PORTS-1:0]     elig;
  logic [N_PORTS-1:0]     grant;
  logic [N_PORTS-1:0]     rsp_dec;
  logic [VPAGE_WIDTH-1:0] sel_vpage;
  logic                   cnt_zero;

  always_comb begin
    can_load  = !lk_valid_q || lk_rdy;
    found     = 1'b0;
    grant_idx = '0;
    elig      = '0;
    for (int unsigned i = 0; i < N_PORTS; i++)
      elig[i] = cl_req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    // Round-robin as two linear scans: ports at/after the pointer, then wrap to the rest.
    for (int unsigned i = 0; i < N_PORTS; i++)
      if (!found && elig[i] && (TAG_WIDTH'(i) >= ptr_q)) begin
        found     = 1'b1;
        grant_idx = TAG_WIDTH'(i);
      end
    for (int unsigned i = 0; i < N_PORTS; i++)
      if (!found && elig[i]) begin
        found     = 1'b1;
        grant_idx = TAG_WIDTH'(i);
      end

    grant     = '0;
    rsp_dec   = '0;
    sel_vpage = '0;
    cnt_zero  = 1'b1;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      grant[i]   = can_load && found && (grant_idx == TAG_WIDTH'(i));
      rsp_dec[i] = rsp_valid && (rsp_tag == TAG_WIDTH'(i)) && (cnt_q[i] != '0);
      if (grant[i]) sel_vpage = cl_req_vpage[i*VPAGE_WIDTH +: VPAGE_WIDTH];
      cnt_d[i]   = cnt_q[i] + CNT_W'(grant[i]) - CNT_W'(rsp_dec[i]);
      if (cnt_q[i] != '0) cnt_zero = 1'b0;
    end

    lk_valid_d = lk_valid_q;
    lk_vpage_d = lk_vpage_q;
    lk_tag_d   = lk_tag_q;
    ptr_d      = ptr_q;
    if (can_load) lk_valid_d = found;
    if (can_load && found) begin
      lk_vpage_d = sel_vpage;
      lk_tag_d   = grant_idx;
      ptr_d      = (grant_idx == TAG_WIDTH'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end

    rsp_valid_d = rsp_dec;
    rsp_ppage_d = (|rsp_dec) ? rsp_ppage : rsp_ppage_q;
    rsp_error_d = (|rsp_dec) ? rsp_error : rsp_error_q;
    orphan_d    = orphan_q || (rsp_valid && !(|rsp_dec));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lk_valid_q  <= 1'b0;
      lk_vpage_q  <= '0;
      lk_tag_q    <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_ppage_q <= '0;
      rsp_error_q <= 1'b0;
      orphan_q    <= 1'b0;
      for (int unsigned i = 0; i < N_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      lk_valid_q  <= lk_valid_d;
      lk_vpage_q  <= lk_vpage_d;
      lk_tag_q    <= lk_tag_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ppage_q <= rsp_ppage_d;
      rsp_error_q <= rsp_error_d;
      orphan_q    <= orphan_d;
      for (int unsigned i = 0; i < N_PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cl_req_rdy     = grant;
  assign lk_valid       = lk_valid_q;
  assign lk_vpage       = lk_vpage_q;
  assign lk_tag         = lk_tag_q;
  assign cl_rsp_valid   = rsp_valid_q;
  assign cl_rsp_ppage   = rsp_ppage_q;
  assign cl_rsp_error   = rsp_error_q;
  assign err_orphan_rsp = orphan_q;
  assign idle           = !lk_valid_q && cnt_zero;

endmodule

// File: tb/tb_cci_mpf_svc_vtp_req_funnel.sv
// Directed bench for the VTP request funnel: arbitration, backpressure, credits, responses.
module tb_cci_mpf_svc_vtp_req_funnel;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cl_req_valid;
  logic [3:0]  cl_req_rdy;
  logic [143:0] cl_req_vpage;
  logic        lk_valid, lk_rdy;
  logic [35:0] lk_vpage;
  logic [1:0]  lk_tag;
  logic        rsp_valid;
  logic [1:0]  rsp_tag;
  logic [31:0] rsp_ppage;
  logic        rsp_error;
  logic [3:0]  cl_rsp_valid;
  logic [31:0] cl_rsp_ppage;
  logic        cl_rsp_error, idle, err_orphan_rsp;

  int passed = 0;
  int total  = 0;

  cci_mpf_svc_vtp_req_funnel #(
    .N_PORTS(4), .VPAGE_WIDTH(36), .PPAGE_WIDTH(32), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cl_req_valid(cl_req_valid), .cl_req_rdy(cl_req_rdy), .cl_req_vpage(cl_req_vpage),
    .lk_valid(lk_valid), .lk_rdy(lk_rdy), .lk_vpage(lk_vpage), .lk_tag(lk_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_ppage(rsp_ppage), .rsp_error(rsp_error),
    .cl_rsp_valid(cl_rsp_valid), .cl_rsp_ppage(cl_rsp_ppage), .cl_rsp_error(cl_rsp_error),
    .idle(idle), .err_orphan_rsp(err_orphan_rsp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_rsp(input logic [1:0] tag, input logic [31:0] pp, input logic er);
    rsp_valid = 1'b1; rsp_tag = tag; rsp_ppage = pp; rsp_error = er;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (lk_valid !== 1'b0) $display("FAIL rst_lk_valid got %b exp 0", lk_valid); else passed++;
    total++; if (lk_vpage !== 36'h0 || lk_tag !== 2'd0) $display("FAIL rst_lk_bus got %h/%0d exp 0/0", lk_vpage, lk_tag); else passed++;
    total++; if (cl_rsp_valid !== 4'b0 || cl_rsp_ppage !== 32'h0 || cl_rsp_error !== 1'b0)
      $display("FAIL rst_rsp got %b/%h/%b exp 0/0/0", cl_rsp_valid, cl_rsp_ppage, cl_rsp_error); else passed++;
    total++; if (idle !== 1'b1 || err_orphan_rsp !== 1'b0) $display("FAIL rst_flags got idle=%b orph=%b exp 1/0", idle, err_orphan_rsp); else passed++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    cl_req_valid = 4'b1111; lk_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (lk_valid !== 1'b1 || lk_tag !== 2'(k % 4))
        $display("FAIL fair_seq[%0d] got v=%b tag=%0d exp v=1 tag=%0d", k, lk_valid, lk_tag, k % 4); else passed++;
    end
    cl_req_valid = 4'b0;
    tick();
    total++; if (lk_valid !== 1'b0) $display("FAIL fair_drop got %b exp 0", lk_valid); else passed++;
    for (int k = 0; k < 8; k++) begin
      issue_rsp(2'(k / 2), 32'h1000 + k, 1'b0);
      total++; if (cl_rsp_valid !== (4'b0001 << (k / 2)))
        $display("FAIL fair_rsp[%0d] got %b exp %b", k, cl_rsp_valid, 4'b0001 << (k / 2)); else passed++;
    end
    tick();
    total++; if (idle !== 1'b1) $display("FAIL fair_idle got %b exp 1", idle); else passed++;
  endtask

  task automatic test_single();
    cl_req_vpage[2*36 +: 36] = 36'h123456789;
    cl_req_valid = 4'b0100;
    #1;
    total++; if (cl_req_rdy !== 4'b0100) $display("FAIL single_rdy got %b exp 0100", cl_req_rdy); else passed++;
    tick();
    cl_req_valid = 4'b0;
    total++; if (lk_valid !== 1'b1 || lk_tag !== 2'd2 || lk_vpage !== 36'h123456789)
      $display("FAIL single_lk got v=%b tag=%0d vp=%h exp 1/2/123456789", lk_valid, lk_tag, lk_vpage); else passed++;
    total++; if (idle !== 1'b0) $display("FAIL single_busy got %b exp 0", idle); else passed++;
    tick();
    total++; if (lk_valid !== 1'b0 || idle !== 1'b0) $display("FAIL single_wait got v=%b idle=%b exp 0/0", lk_valid, idle); else passed++;
    issue_rsp(2'd2, 32'hABCDE, 1'b0);
    total++; if (cl_rsp_valid !== 4'b0100 || cl_rsp_ppage !== 32'hABCDE)
      $display("FAIL single_rsp got %b/%h exp 0100/000abcde", cl_rsp_valid, cl_rsp_ppage); else passed++;
    total++; if (idle !== 1'b1) $display("FAIL single_idle got %b exp 1", idle); else passed++;
    tick();
    total++; if (cl_rsp_valid !== 4'b0 || cl_rsp_ppage !== 32'hABCDE)
      $display("FAIL single_hold got %b/%h exp 0000/000abcde", cl_rsp_valid, cl_rsp_ppage); else passed++;
  endtask

  task automatic test_backpressure();
    cl_req_vpage[0 +: 36]  = 36'hA_AAAA_0000;
    cl_req_vpage[36 +: 36] = 36'hB_BBBB_1111;
    lk_rdy = 1'b0; cl_req_valid = 4'b0001;
    tick();
    cl_req_valid = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (cl_req_rdy !== 4'b0 || lk_valid !== 1'b1 || lk_tag !== 2'd0 || lk_vpage !== 36'hA_AAAA_0000)
        $display("FAIL bp_hold[%0d] got rdy=%b v=%b tag=%0d vp=%h exp 0000/1/0/aaaaa0000", k, cl_req_rdy, lk_valid, lk_tag, lk_vpage);
      else passed++;
      tick();
    end
    lk_rdy = 1'b1;
    #1;
    total++; if (cl_req_rdy !== 4'b0010) $display("FAIL bp_release_rdy got %b exp 0010", cl_req_rdy); else passed++;
    tick();
    cl_req_valid = 4'b0;
    total++; if (lk_valid !== 1'b1 || lk_tag !== 2'd1 || lk_vpage !== 36'hB_BBBB_1111)
      $display("FAIL bp_next got v=%b tag=%0d vp=%h exp 1/1/bbbbb1111", lk_valid, lk_tag, lk_vpage); else passed++;
    tick();
    total++; if (lk_valid !== 1'b0) $display("FAIL bp_drop got %b exp 0", lk_valid); else passed++;
    issue_rsp(2'd0, 32'h0000_0A0A, 1'b0);
    total++; if (cl_rsp_valid !== 4'b0001 || cl_rsp_ppage !== 32'h0000_0A0A)
      $display("FAIL bp_rsp0 got %b/%h exp 0001/00000a0a", cl_rsp_valid, cl_rsp_ppage); else passed++;
    issue_rsp(2'd1, 32'h0000_0B0B, 1'b0);
    total++; if (cl_rsp_valid !== 4'b0010 || cl_rsp_ppage !== 32'h0000_0B0B)
      $display("FAIL bp_rsp1 got %b/%h exp 0010/00000b0b", cl_rsp_valid, cl_rsp_ppage); else passed++;
  endtask

  task automatic test_credit_limit();
    cl_req_valid = 4'b0010; lk_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (lk_valid !== 1'b1 || lk_tag !== 2'd1) $display("FAIL cred_fill[%0d] got v=%b tag=%0d exp 1/1", k, lk_valid, lk_tag); else passed++;
    end
    cl_req_valid = 4'b0011;
    #1;
    total++; if (cl_req_rdy !== 4'b0001) $display("FAIL cred_sat_rdy got %b exp 0001", cl_req_rdy); else passed++;
    tick();
    total++; if (lk_tag !== 2'd0) $display("FAIL cred_port0 got tag=%0d exp 0", lk_tag); else passed++;
    cl_req_valid = 4'b0010;
    rsp_valid = 1'b1; rsp_tag = 2'd1; rsp_ppage = 32'h0000_1111; rsp_error = 1'b0;
    #1;
    total++; if (cl_req_rdy !== 4'b0) $display("FAIL cred_still_sat got %b exp 0000", cl_req_rdy); else passed++;
    tick();
    rsp_valid = 1'b0;
    total++; if (cl_rsp_valid !== 4'b0010) $display("FAIL cred_rsp got %b exp 0010", cl_rsp_valid); else passed++;
    total++; if (cl_req_rdy !== 4'b0010) $display("FAIL cred_reopen got %b exp 0010", cl_req_rdy); else passed++;
    tick();
    cl_req_valid = 4'b0;
    total++; if (lk_valid !== 1'b1 || lk_tag !== 2'd1) $display("FAIL cred_reissue got v=%b tag=%0d exp 1/1", lk_valid, lk_tag); else passed++;
    issue_rsp(2'd0, 32'h0000_2222, 1'b0);
    for (int k = 0; k < 8; k++) begin
      issue_rsp(2'd1, 32'h0000_3333, 1'b0);
      total++; if (cl_rsp_valid !== 4'b0010) $display("FAIL cred_drain[%0d] got %b exp 0010", k, cl_rsp_valid); else passed++;
    end
    tick();
    total++; if (idle !== 1'b1) $display("FAIL cred_idle got %b exp 1", idle); else passed++;
  endtask

  task automatic test_simultaneous();
    cl_req_valid = 4'b1000; lk_rdy = 1'b1;
    repeat (5) tick();
    total++; if (lk_tag !== 2'd3) $display("FAIL sim_fill got tag=%0d exp 3", lk_tag); else passed++;
    rsp_valid = 1'b1; rsp_tag = 2'd3; rsp_ppage = 32'h0000_4444; rsp_error = 1'b1;
    #1;
    total++; if (cl_req_rdy !== 4'b1000) $display("FAIL sim_rdy got %b exp 1000", cl_req_rdy); else passed++;
    tick();
    rsp_valid = 1'b0; cl_req_valid = 4'b0;
    total++; if (cl_rsp_valid !== 4'b1000 || cl_rsp_error !== 1'b1 || cl_rsp_ppage !== 32'h0000_4444)
      $display("FAIL sim_rsp got %b/%b/%h exp 1000/1/00004444", cl_rsp_valid, cl_rsp_error, cl_rsp_ppage); else passed++;
    for (int k = 0; k < 5; k++) begin
      issue_rsp(2'd3, 32'h0000_5550 + k, 1'b0);
      total++; if (cl_rsp_valid !== 4'b1000 || cl_rsp_error !== 1'b0)
        $display("FAIL sim_drain[%0d] got %b/%b exp 1000/0", k, cl_rsp_valid, cl_rsp_error); else passed++;
    end
    tick();
    total++; if (idle !== 1'b1 || err_orphan_rsp !== 1'b0)
      $display("FAIL sim_idle got idle=%b orph=%b exp 1/0", idle, err_orphan_rsp); else passed++;
  endtask

  task automatic test_orphan();
    issue_rsp(2'd0, 32'hDEAD_BEEF, 1'b1);
    total++; if (cl_rsp_valid !== 4'b0 || err_orphan_rsp !== 1'b1)
      $display("FAIL orph_flag got %b/%b exp 0000/1", cl_rsp_valid, err_orphan_rsp); else passed++;
    total++; if (cl_rsp_ppage !== 32'h0000_5554 || cl_rsp_error !== 1'b0)
      $display("FAIL orph_nocap got %h/%b exp 00005554/0", cl_rsp_ppage, cl_rsp_error); else passed++;
    repeat (3) tick();
    total++; if (err_orphan_rsp !== 1'b1 || idle !== 1'b1)
      $display("FAIL orph_sticky got orph=%b idle=%b exp 1/1", err_orphan_rsp, idle); else passed++;
  endtask

  task automatic test_reset_mid();
    cl_req_valid = 4'b1111; lk_rdy = 1'b0;
    tick();
    total++; if (lk_valid !== 1'b1 || idle !== 1'b0) $display("FAIL rmid_pre got v=%b idle=%b exp 1/0", lk_valid, idle); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (lk_valid !== 1'b0 || lk_vpage !== 36'h0 || lk_tag !== 2'd0)
      $display("FAIL rmid_lk got %b/%h/%0d exp 0/0/0", lk_valid, lk_vpage, lk_tag); else passed++;
    total++; if (cl_rsp_valid !== 4'b0 || cl_rsp_ppage !== 32'h0 || cl_rsp_error !== 1'b0)
      $display("FAIL rmid_rsp got %b/%h/%b exp 0/0/0", cl_rsp_valid, cl_rsp_ppage, cl_rsp_error); else passed++;
    total++; if (idle !== 1'b1 || err_orphan_rsp !== 1'b0)
      $display("FAIL rmid_flags got idle=%b orph=%b exp 1/0", idle, err_orphan_rsp); else passed++;
    cl_req_valid = 4'b0;
    tick();
    reset = 1'b1;
    tick();
    cl_req_valid = 4'b1111; lk_rdy = 1'b1;
    #1;
    total++; if (cl_req_rdy !== 4'b0001) $display("FAIL rmid_ptr got %b exp 0001", cl_req_rdy); else passed++;
    tick();
    cl_req_valid = 4'b0;
    total++; if (lk_tag !== 2'd0 || lk_valid !== 1'b1) $display("FAIL rmid_issue got v=%b tag=%0d exp 1/0", lk_valid, lk_tag); else passed++;
  endtask

  initial begin
    reset = 1'b0; cl_req_valid = '0; cl_req_vpage = '0; lk_rdy = 1'b0;
    rsp_valid = 1'b0; rsp_tag = '0; rsp_ppage = '0; rsp_error = 1'b0;
    test_reset();
    test_fairness();
    test_single();
    test_backpressure();
    test_credit_limit();
    test_simultaneous();
    test_orphan();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
